// File: rtl/iter_div_unit.sv
// Sequential radix-2 non-restoring integer divider with signed/unsigned modes,
// division-by-zero and signed-overflow fast paths, tag pass-through and kill.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_by_zero,
    output logic             out_overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [WIDTH:0]     prem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvsr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               dbz_r;
    logic               ovf_r;

    logic               sign_z_s;
    logic               sign_d_s;
    logic [WIDTH-1:0]   mag_z_s;
    logic [WIDTH-1:0]   mag_d_s;
    logic               is_zero_s;
    logic               is_ovf_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     next_p_s;
    logic [WIDTH:0]     rem_fix_s;
    logic [WIDTH-1:0]   min_val_s;

    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand decode: signs, magnitudes and special-case detection on the request.
    always_comb begin
        min_val_s = {1'b1, {(WIDTH-1){1'b0}}};
        sign_z_s  = in_signed & in_dividend[WIDTH-1];
        sign_d_s  = in_signed & in_divisor[WIDTH-1];
        mag_z_s   = sign_z_s ? neg2(in_dividend) : in_dividend;
        mag_d_s   = sign_d_s ? neg2(in_divisor) : in_divisor;
        is_zero_s = (in_divisor == {WIDTH{1'b0}});
        is_ovf_s  = in_signed && (in_dividend == min_val_s) && (in_divisor == {WIDTH{1'b1}});
    end

    // One non-restoring step plus the final remainder correction.
    always_comb begin
        shifted_s = {prem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        if (prem_r[WIDTH]) begin
            next_p_s  = shifted_s + {1'b0, dvsr_r};
            rem_fix_s = prem_r + {1'b0, dvsr_r};
        end else begin
            next_p_s  = shifted_s - {1'b0, dvsr_r};
            rem_fix_s = prem_r;
        end
    end

    // Control FSM and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            prem_r          <= {(WIDTH+1){1'b0}};
            quo_r           <= {WIDTH{1'b0}};
            dvsr_r          <= {WIDTH{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            neg_q_r         <= 1'b0;
            neg_r_r         <= 1'b0;
            dbz_r           <= 1'b0;
            ovf_r           <= 1'b0;
            in_ready        <= 1'b1;
            busy            <= 1'b0;
            out_valid       <= 1'b0;
            out_quotient    <= {WIDTH{1'b0}};
            out_remainder   <= {WIDTH{1'b0}};
            out_tag         <= {TAG_W{1'b0}};
            out_div_by_zero <= 1'b0;
            out_overflow    <= 1'b0;
        end else if (kill) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        out_tag  <= in_tag;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        // Special cases preload FIX with the final answer so the
                        // result appears exactly one cycle after accept.
                        if (is_zero_s) begin
                            quo_r   <= {WIDTH{1'b1}};
                            prem_r  <= {1'b0, in_dividend};
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            dbz_r   <= 1'b1;
                            ovf_r   <= 1'b0;
                            state_r <= FIX;
                        end else if (is_ovf_s) begin
                            quo_r   <= min_val_s;
                            prem_r  <= {(WIDTH+1){1'b0}};
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            dbz_r   <= 1'b0;
                            ovf_r   <= 1'b1;
                            state_r <= FIX;
                        end else begin
                            quo_r   <= mag_z_s;
                            dvsr_r  <= mag_d_s;
                            prem_r  <= {(WIDTH+1){1'b0}};
                            cnt_r   <= CNT_W'(WIDTH-1);
                            neg_q_r <= sign_z_s ^ sign_d_s;
                            neg_r_r <= sign_z_s;
                            dbz_r   <= 1'b0;
                            ovf_r   <= 1'b0;
                            state_r <= ITER;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ITER: begin
                    prem_r <= next_p_s;
                    quo_r  <= {quo_r[WIDTH-2:0], ~next_p_s[WIDTH]};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    out_quotient    <= neg_q_r ? neg2(quo_r) : quo_r;
                    out_remainder   <= neg_r_r ? neg2(rem_fix_s[WIDTH-1:0]) : rem_fix_s[WIDTH-1:0];
                    out_div_by_zero <= dbz_r;
                    out_overflow    <= ovf_r;
                    out_valid       <= 1'b1;
                    state_r         <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
